// File: rtl/traffic_pkg.sv
// Shared codes, reset defaults and the timer state encoding for the
// traffic-light timing controller.
package traffic_pkg;

   localparam logic [1:0] INT_BASE = 2'b00;
   localparam logic [1:0] INT_EXT  = 2'b01;
   localparam logic [1:0] INT_YEL  = 2'b10;
   localparam logic [1:0] INT_WALK = 2'b11;

   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;

   localparam logic [3:0] DEF_BASE = 4'd6;
   localparam logic [3:0] DEF_EXT  = 4'd3;
   localparam logic [3:0] DEF_YEL  = 4'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_COUNT  = 2'b01,
      ST_EXPIRE = 2'b10
   } timer_state_e;

   // A programmed zero still gives a one-second interval.
   function automatic logic [3:0] clamp_min_one(input logic [3:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

endpackage

// File: rtl/light_timer_ctrl_if.sv
// Reprogram, start and status signals between the light FSM / switch inputs
// (master) and the timing controller (slave).
interface light_timer_ctrl_if;
   logic       reprogram;
   logic [1:0] time_parameter_selector;
   logic [3:0] time_value;
   logic       start_timer;
   logic [1:0] interval;
   logic       expired;
   logic       busy;
   logic [3:0] remaining;
   logic       tick;
   logic       param_updated;

   modport master (
      output reprogram, time_parameter_selector, time_value, start_timer, interval,
      input  expired, busy, remaining, tick, param_updated
   );

   modport slave (
      input  reprogram, time_parameter_selector, time_value, start_timer, interval,
      output expired, busy, remaining, tick, param_updated
   );
endinterface

// File: rtl/tick_divider.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick on the last
// count; clear restarts the second so a new interval gets a full first second.
module tick_divider #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic g_reset,
   input  logic clear,
   output logic tick
);
   localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Divider counter with clear and wrap.
   always_ff @(posedge clk or posedge g_reset) begin
      if (g_reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == LAST);
endmodule

// File: rtl/light_timer_ctrl.sv
// Interval parameter storage, reprogram edge detection and the single
// countdown that reports interval expiry back to the light FSM.
module light_timer_ctrl #(
   parameter int         TICK_DIV = 25_000_000,
   parameter logic [3:0] DEF_BASE = traffic_pkg::DEF_BASE,
   parameter logic [3:0] DEF_EXT  = traffic_pkg::DEF_EXT,
   parameter logic [3:0] DEF_YEL  = traffic_pkg::DEF_YEL
) (
   input logic               clk,
   input logic               g_reset,
   light_timer_ctrl_if.slave tif
);
   import traffic_pkg::*;

   logic         r_rp_q;
   logic         r_param_updated;
   logic [3:0]   r_t_base;
   logic [3:0]   r_t_ext;
   logic [3:0]   r_t_yel;
   timer_state_e r_state;
   timer_state_e w_state_nxt;
   logic [3:0]   r_remaining;
   logic [3:0]   w_remaining_nxt;
   logic [3:0]   w_load_raw;
   logic [3:0]   w_load_val;
   logic         w_rp_edge;
   logic         w_start;
   logic         w_tick;

   assign w_rp_edge = tif.reprogram & ~r_rp_q;
   // An abort in the same cycle wins over a start, so the divider is not cleared then.
   assign w_start   = tif.start_timer & ~w_rp_edge;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clk     (clk),
      .g_reset (g_reset),
      .clear   (w_start),
      .tick    (w_tick)
   );

   // Reprogram edge detect and parameter writes.
   always_ff @(posedge clk or posedge g_reset) begin
      if (g_reset) begin
         r_rp_q          <= 1'b0;
         r_param_updated <= 1'b0;
         r_t_base        <= DEF_BASE;
         r_t_ext         <= DEF_EXT;
         r_t_yel         <= DEF_YEL;
      end else begin
         r_rp_q          <= tif.reprogram;
         r_param_updated <= w_rp_edge & (tif.time_parameter_selector != 2'b11);
         if (w_rp_edge) begin
            case (tif.time_parameter_selector)
               SEL_BASE: r_t_base <= tif.time_value;
               SEL_EXT:  r_t_ext  <= tif.time_value;
               SEL_YEL:  r_t_yel  <= tif.time_value;
               default:  ;
            endcase
         end
      end
   end

   // Interval selection from the currently stored parameters.
   always_comb begin
      w_load_raw = r_t_ext;
      case (tif.interval)
         INT_BASE: w_load_raw = r_t_base;
         INT_EXT:  w_load_raw = r_t_ext;
         INT_YEL:  w_load_raw = r_t_yel;
         INT_WALK: w_load_raw = r_t_ext;
         default:  w_load_raw = r_t_ext;
      endcase
      w_load_val = clamp_min_one(w_load_raw);
   end

   // Countdown next-state logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      if (w_rp_edge) begin
         w_state_nxt     = ST_IDLE;
         w_remaining_nxt = 4'd0;
      end else if (tif.start_timer) begin
         w_state_nxt     = ST_COUNT;
         w_remaining_nxt = w_load_val;
      end else begin
         case (r_state)
            ST_COUNT: begin
               if (w_tick) begin
                  if (r_remaining <= 4'd1) begin
                     w_state_nxt     = ST_EXPIRE;
                     w_remaining_nxt = 4'd0;
                  end else begin
                     w_remaining_nxt = r_remaining - 4'd1;
                  end
               end else begin
                  w_remaining_nxt = r_remaining;
               end
            end
            ST_EXPIRE: begin
               w_state_nxt     = ST_IDLE;
               w_remaining_nxt = 4'd0;
            end
            ST_IDLE: begin
               w_state_nxt     = ST_IDLE;
               w_remaining_nxt = 4'd0;
            end
            default: begin
               w_state_nxt     = ST_IDLE;
               w_remaining_nxt = 4'd0;
            end
         endcase
      end
   end

   // Countdown state register.
   always_ff @(posedge clk or posedge g_reset) begin
      if (g_reset) begin
         r_state     <= ST_IDLE;
         r_remaining <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   assign tif.busy          = (r_state == ST_COUNT);
   assign tif.expired       = (r_state == ST_EXPIRE);
   assign tif.remaining     = r_remaining;
   assign tif.tick          = w_tick;
   assign tif.param_updated = r_param_updated;
endmodule

// File: tb/tb_light_timer_ctrl.sv
// Directed bench for light_timer_ctrl with TICK_DIV=4.
module tb_light_timer_ctrl;
   logic clk;
   logic g_reset;
   int   n_cmp;
   int   n_err;
   int   cyc;
   int   pulses;

   light_timer_ctrl_if tif ();

   light_timer_ctrl #(.TICK_DIV(4)) dut (
      .clk     (clk),
      .g_reset (g_reset),
      .tif     (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Steps until expired is seen; cycles = -1 if the bound runs out.
   task automatic wait_expired(input int max_cyc, output int cycles);
      cycles = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         step();
         if (tif.expired === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic start(input logic [1:0] intv);
      tif.start_timer = 1'b1;
      tif.interval    = intv;
      step();
      tif.start_timer = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      g_reset = 1'b1;
      tif.reprogram = 1'b0;
      tif.time_parameter_selector = 2'b00;
      tif.time_value = 4'd0;
      tif.start_timer = 1'b0;
      tif.interval = 2'b00;
      step();
      step();
      chk("rst_expired", 32'(tif.expired), 32'd0);
      chk("rst_busy", 32'(tif.busy), 32'd0);
      chk("rst_tick", 32'(tif.tick), 32'd0);
      chk("rst_remaining", 32'(tif.remaining), 32'd0);
      chk("rst_param_updated", 32'(tif.param_updated), 32'd0);
      g_reset = 1'b0;
      step();
      step();

      // 1: base interval, 6 s * 4 cycles
      start(2'b00);
      chk("t1_busy", 32'(tif.busy), 32'd1);
      chk("t1_remaining", 32'(tif.remaining), 32'd6);
      chk("t1_tick_cleared", 32'(tif.tick), 32'd0);
      step(); step(); step();
      chk("t1_tick_first", 32'(tif.tick), 32'd1);
      chk("t1_remaining_pre_tick", 32'(tif.remaining), 32'd6);
      wait_expired(40, cyc);
      chk("t1_expire_latency", 32'(cyc + 3), 32'd24);
      chk("t1_remaining_at_expire", 32'(tif.remaining), 32'd0);
      step();
      chk("t1_expired_single", 32'(tif.expired), 32'd0);
      chk("t1_idle_busy", 32'(tif.busy), 32'd0);

      // 2: ext interval
      start(2'b01);
      chk("t2_busy", 32'(tif.busy), 32'd1);
      chk("t2_remaining", 32'(tif.remaining), 32'd3);
      step(); step(); step(); step();
      chk("t2_remaining_after_1s", 32'(tif.remaining), 32'd2);
      wait_expired(20, cyc);
      chk("t2_expire_latency", 32'(cyc + 4), 32'd12);
      step();
      chk("t2_expired_single", 32'(tif.expired), 32'd0);

      // 3: held reprogram writes base=10 once
      tif.time_parameter_selector = 2'b00;
      tif.time_value = 4'd10;
      tif.reprogram = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         pulses += int'(tif.param_updated);
      end
      tif.reprogram = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(tif.param_updated);
      end
      chk("t3_param_pulses", 32'(pulses), 32'd1);
      start(2'b00);
      chk("t3_remaining", 32'(tif.remaining), 32'd10);
      wait_expired(60, cyc);
      chk("t3_expire_latency", 32'(cyc), 32'd40);
      step();

      // 4: yellow programmed to 0 runs for 1 s
      tif.time_parameter_selector = 2'b10;
      tif.time_value = 4'd0;
      tif.reprogram = 1'b1;
      step();
      chk("t4_param_updated", 32'(tif.param_updated), 32'd1);
      tif.reprogram = 1'b0;
      step();
      chk("t4_param_updated_clear", 32'(tif.param_updated), 32'd0);
      start(2'b10);
      chk("t4_remaining", 32'(tif.remaining), 32'd1);
      wait_expired(20, cyc);
      chk("t4_expire_latency", 32'(cyc), 32'd4);
      step();

      // 5: restart mid-run, then selector 11 write
      start(2'b01);
      for (int i = 0; i < 10; i++) step();
      chk("t5_remaining_mid", 32'(tif.remaining), 32'd1);
      start(2'b01);
      chk("t5_restart_remaining", 32'(tif.remaining), 32'd3);
      chk("t5_restart_busy", 32'(tif.busy), 32'd1);
      wait_expired(30, cyc);
      chk("t5_expire_latency", 32'(cyc), 32'd12);
      step();
      tif.time_parameter_selector = 2'b11;
      tif.time_value = 4'd5;
      tif.reprogram = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(tif.param_updated);
      end
      tif.reprogram = 1'b0;
      step();
      chk("t5_sel11_pulses", 32'(pulses), 32'd0);

      // 6: async reset mid-count restores defaults
      start(2'b00);
      chk("t6_base_kept", 32'(tif.remaining), 32'd10);
      for (int i = 0; i < 5; i++) step();
      g_reset = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(tif.busy), 32'd0);
      chk("t6_rst_remaining", 32'(tif.remaining), 32'd0);
      chk("t6_rst_tick", 32'(tif.tick), 32'd0);
      step();
      g_reset = 1'b0;
      step();
      start(2'b00);
      chk("t6_def_base", 32'(tif.remaining), 32'd6);
      start(2'b01);
      chk("t6_def_ext", 32'(tif.remaining), 32'd3);
      start(2'b10);
      chk("t6_def_yel", 32'(tif.remaining), 32'd2);
      start(2'b11);
      chk("t6_walk", 32'(tif.remaining), 32'd3);

      // 6b: reprogram edge aborts a running countdown
      start(2'b00);
      for (int i = 0; i < 6; i++) step();
      tif.time_parameter_selector = 2'b11;
      tif.reprogram = 1'b1;
      step();
      chk("t6_abort_busy", 32'(tif.busy), 32'd0);
      chk("t6_abort_remaining", 32'(tif.remaining), 32'd0);
      tif.reprogram = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         pulses += int'(tif.expired);
      end
      chk("t6_abort_no_expired", 32'(pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
